// File: rtl/seq_divider.sv
// seq_divider: sequential 8-bit by 4-bit restoring divider started on a falling edge of start
module seq_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] src1,
  input  logic [3:0] src2,
  input  logic       start,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       valid,
  output logic       busy,
  output logic       div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t     r_state, w_next;
  logic       r_start_d, r_dz;
  logic [7:0] r_dividend, r_quot;
  logic [3:0] r_divisor, r_rem;
  logic [2:0] r_cnt;
  logic       w_start_edge, w_accept, w_done, w_qbit;
  logic [4:0] w_t, w_diff;
  logic [3:0] w_rem_next;
  assign w_start_edge = !start & r_start_d;
  assign w_accept     = (r_state == IDLE) & w_start_edge;
  assign w_done       = (r_state == CALC) & (r_dz | (r_cnt == 3'd0));
  assign w_t          = {r_rem, r_dividend[r_cnt]};
  assign w_diff       = w_t - {1'b0, r_divisor};
  assign w_qbit       = w_t >= {1'b0, r_divisor};
  assign w_rem_next   = w_qbit ? w_diff[3:0] : w_t[3:0];
  // state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end
  // next state and status outputs; the divide-by-zero path spends one CALC cycle before DONE
  always_comb begin
    w_next = r_state;
    valid  = 1'b0;
    busy   = 1'b0;
    w_next = (r_state == IDLE) ? (w_accept ? CALC : IDLE) :
             (r_state == CALC) ? (w_done ? DONE : CALC) : IDLE;
    valid  = r_state == DONE;
    busy   = r_state != IDLE;
  end
  // edge detect, operand capture, one quotient bit per cycle, and result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_start_d   <= 1'b0;
      r_dz        <= 1'b0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r_start_d <= start;
      if (w_accept) begin
        r_dividend <= src1;
        r_divisor  <= src2;
        r_rem      <= '0;
        r_quot     <= '0;
        r_cnt      <= 3'd7;
        r_dz       <= src2 == 4'd0;
      end else if (r_state == CALC && !r_dz) begin
        r_rem  <= w_rem_next;
        r_quot <= {r_quot[6:0], w_qbit};
        r_cnt  <= r_cnt - 3'd1;
      end
      if (w_done) begin
        quotient    <= r_dz ? 8'hFF : {r_quot[6:0], w_qbit};
        remainder   <= r_dz ? r_dividend[3:0] : w_rem_next;
        div_by_zero <= r_dz;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider
module tb_seq_divider;
  logic       clk = 0;
  logic       rst = 0;
  logic [7:0] src1 = 0;
  logic [3:0] src2 = 0;
  logic       start = 0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       valid, busy, div_by_zero;
  int         errors = 0;
  int         checks = 0;

  seq_divider dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .start(start),
    .quotient(quotient), .remainder(remainder), .valid(valid),
    .busy(busy), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // drives a falling edge on start and ticks until valid or a 20-cycle bound; lat counts edges after the fall
  task automatic start_op(input logic [7:0] a, input logic [3:0] b, output int lat);
    src1 = a;
    src2 = b;
    start = 1;
    tick;
    start = 0;
    lat = 0;
    do begin
      tick;
      lat++;
    end while (!valid && lat < 20);
  endtask

  task automatic test_reset;
    rst = 0;
    tick;
    tick;
    checks++;
    if ({quotient, remainder, div_by_zero, valid, busy} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got q=%0d r=%0d dz=%0b v=%0b b=%0b, want all 0", quotient, remainder, div_by_zero, valid, busy);
    end
    rst = 1;
    tick;
  endtask

  task automatic test_basic;
    int lat;
    start_op(8'd200, 4'd7, lat);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL basic_latency: got %0d, want 9", lat);
    end
    checks++;
    if ({quotient, remainder, div_by_zero, busy} !== {8'd28, 4'd4, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL basic_result: got q=%0d r=%0d dz=%0b b=%0b, want q=28 r=4 dz=0 b=1", quotient, remainder, div_by_zero, busy);
    end
    tick;
    checks++;
    if ({valid, busy, quotient, remainder} !== {1'b0, 1'b0, 8'd28, 4'd4}) begin
      errors++;
      $display("FAIL basic_after: got v=%0b b=%0b q=%0d r=%0d, want v=0 b=0 q=28 r=4", valid, busy, quotient, remainder);
    end
  endtask

  task automatic test_vectors;
    logic [7:0] va [3] = '{8'd255, 8'd5, 8'd255};
    logic [3:0] vb [3] = '{4'd1, 4'd9, 4'd15};
    logic [7:0] vq [3] = '{8'd255, 8'd0, 8'd17};
    logic [3:0] vr [3] = '{4'd0, 4'd5, 4'd0};
    logic [7:0] prev_q;
    logic [3:0] prev_r;
    for (int i = 0; i < 3; i++) begin
      int lat;
      prev_q = quotient;
      prev_r = remainder;
      src1 = va[i];
      src2 = vb[i];
      start = 1;
      tick;
      start = 0;
      lat = 0;
      do begin
        tick;
        lat++;
        if (lat == 5) begin
          checks++;
          if ({quotient, remainder} !== {prev_q, prev_r}) begin
            errors++;
            $display("FAIL hold_during_calc[%0d]: got q=%0d r=%0d, want q=%0d r=%0d", i, quotient, remainder, prev_q, prev_r);
          end
        end
      end while (!valid && lat < 20);
      checks++;
      if ({lat[4:0], quotient, remainder, div_by_zero} !== {5'd9, vq[i], vr[i], 1'b0}) begin
        errors++;
        $display("FAIL vector[%0d]: got lat=%0d q=%0d r=%0d dz=%0b, want lat=9 q=%0d r=%0d dz=0", i, lat, quotient, remainder, div_by_zero, vq[i], vr[i]);
      end
      tick;
    end
  endtask

  task automatic test_div_zero;
    int busy_cnt = 0;
    src1 = 8'd100;
    src2 = 4'd0;
    start = 1;
    tick;
    start = 0;
    tick;
    busy_cnt += int'(busy);
    checks++;
    if ({busy, valid} !== 2'b10) begin
      errors++;
      $display("FAIL dz_e0: got b=%0b v=%0b, want b=1 v=0", busy, valid);
    end
    tick;
    busy_cnt += int'(busy);
    checks++;
    if ({valid, quotient, remainder, div_by_zero} !== {1'b1, 8'hFF, 4'd4, 1'b1}) begin
      errors++;
      $display("FAIL dz_result: got v=%0b q=%h r=%0d dz=%0b, want v=1 q=ff r=4 dz=1", valid, quotient, remainder, div_by_zero);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      busy_cnt += int'(busy);
    end
    checks++;
    if (busy_cnt !== 2) begin
      errors++;
      $display("FAIL dz_busy_cycles: got %0d, want 2", busy_cnt);
    end
  endtask

  task automatic test_ignore_in_flight;
    int pulses = 0;
    logic [7:0] q_seen = 0;
    logic [3:0] r_seen = 0;
    src1 = 8'd200;
    src2 = 4'd7;
    start = 1;
    tick;
    start = 0;
    tick;
    tick;
    tick;
    tick;
    src1 = 8'd50;
    src2 = 4'd3;
    start = 1;
    tick;
    start = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (valid) begin
        pulses++;
        q_seen = quotient;
        r_seen = remainder;
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL ignore_pulses: got %0d, want 1", pulses);
    end
    checks++;
    if ({q_seen, r_seen, busy} !== {8'd28, 4'd4, 1'b0}) begin
      errors++;
      $display("FAIL ignore_result: got q=%0d r=%0d b=%0b, want q=28 r=4 b=0", q_seen, r_seen, busy);
    end
  endtask

  task automatic test_back_to_back;
    src1 = 8'd200;
    src2 = 4'd7;
    start = 1;
    tick;
    start = 0;
    for (int i = 0; i < 8; i++) tick;
    start = 1;
    tick;
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: got v=%0b, want 1", valid);
    end
    start = 0;
    tick;
    tick;
    checks++;
    if ({busy, valid} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_edge_in_done: got b=%0b v=%0b, want b=0 v=0", busy, valid);
    end
  endtask

  task automatic test_reset_mid_calc;
    int pulses = 0;
    int lat;
    src1 = 8'd200;
    src2 = 4'd7;
    start = 1;
    tick;
    start = 0;
    for (int i = 0; i < 5; i++) tick;
    rst = 0;
    tick;
    rst = 1;
    checks++;
    if ({busy, valid, quotient, remainder, div_by_zero} !== 15'd0) begin
      errors++;
      $display("FAIL mid_reset: got b=%0b v=%0b q=%0d r=%0d dz=%0b, want all 0", busy, valid, quotient, remainder, div_by_zero);
    end
    for (int i = 0; i < 12; i++) begin
      tick;
      pulses += int'(valid);
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL mid_reset_no_valid: got %0d pulses, want 0", pulses);
    end
    start_op(8'd200, 4'd7, lat);
    checks++;
    if ({lat[4:0], quotient, remainder} !== {5'd9, 8'd28, 4'd4}) begin
      errors++;
      $display("FAIL mid_reset_rerun: got lat=%0d q=%0d r=%0d, want lat=9 q=28 r=4", lat, quotient, remainder);
    end
    tick;
  endtask

  task automatic test_no_edge;
    int act = 0;
    start = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      act += int'(busy | valid);
    end
    start = 1;
    for (int i = 0; i < 8; i++) begin
      tick;
      act += int'(busy | valid);
    end
    checks++;
    if (act !== 0) begin
      errors++;
      $display("FAIL hold_level_rise: got %0d active cycles, want 0", act);
    end
    rst = 0;
    tick;
    rst = 1;
    start = 0;
    act = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      act += int'(busy | valid);
    end
    checks++;
    if (act !== 0) begin
      errors++;
      $display("FAIL post_reset_edge: got %0d active cycles, want 0", act);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_vectors;
    test_div_zero;
    test_ignore_in_flight;
    test_back_to_back;
    test_reset_mid_calc;
    test_no_edge;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
